// File: rtl/rv64_defs.sv
// Shared definitions for the RV64 front end: the canonical NOP, the boot
// address and the fetch-stage state encoding.
package rv64_defs;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register. The fetch FSM chooses between holding,
// loading a redirect target (forced to 4-byte alignment) and stepping by 4.
module pc_reg
    import rv64_defs::*;
#(
    parameter int              DW       = 64,
    parameter logic [DW-1:0]   RESET_PC = rv64_defs::RESET_PC[DW-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [DW-1:0] load_addr,
    input  logic          inc_en,
    output logic [DW-1:0] pc
);

    // PC update: reset, then redirect, then sequential step (wraps naturally).
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load_en) begin
            pc <= {load_addr[DW-1:2], 2'b00};
        end else if (inc_en) begin
            pc <= pc + DW'(4);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage. Issues one memory request at a time, squashes
// responses made stale by a redirect, and presents the fetched instruction
// to the IF/ID register until it is consumed.
//
// Memory handshake: a request is transferred on a cycle where mem_req_o and
// mem_ready_i are both high; exactly one response (mem_rvalid_i) follows per
// transferred request, and mem_rvalid_i is only meaningful while a request is
// outstanding (WAIT); it is ignored in every other state.
module ifu_fetch
    import rv64_defs::*;
#(
    parameter int            DW       = 64,
    parameter int            IW       = 32,
    parameter logic [DW-1:0] RESET_PC = rv64_defs::RESET_PC[DW-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic [DW-1:0] jump_addr_i,
    input  logic          stall_i,
    output logic          mem_req_o,
    output logic [DW-1:0] mem_addr_o,
    input  logic          mem_ready_i,
    input  logic          mem_rvalid_i,
    input  logic [IW-1:0] mem_rdata_i,
    output logic [IW-1:0] inst_o,
    output logic [DW-1:0] inst_addr_o,
    output logic          inst_valid_o,
    output logic          hold_flag_o,
    output logic [1:0]    fsm_state_o
);

    fetch_state_e  state, state_next;
    logic          drop, drop_next;
    logic [IW-1:0] inst_q, inst_next;
    logic [DW-1:0] inst_addr_q, inst_addr_next;
    logic          valid_q, valid_next;
    logic          pc_load, pc_inc;
    logic [DW-1:0] pc;

    pc_reg #(
        .DW       (DW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_en   (pc_load),
        .load_addr (jump_addr_i),
        .inc_en    (pc_inc),
        .pc        (pc)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            drop        <= 1'b0;
            inst_q      <= INST_NOP[IW-1:0];
            inst_addr_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state       <= state_next;
            drop        <= drop_next;
            inst_q      <= inst_next;
            inst_addr_q <= inst_addr_next;
            valid_q     <= valid_next;
        end
    end

    // Next-state logic; a redirect always beats a stall.
    always_comb begin
        state_next     = state;
        drop_next      = drop;
        inst_next      = inst_q;
        inst_addr_next = inst_addr_q;
        valid_next     = valid_q;
        pc_load        = 1'b0;
        pc_inc         = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
                pc_load    = jump_en_i;
            end
            REQ: begin
                pc_load = jump_en_i;
                if (mem_ready_i) begin
                    state_next = WAIT;
                    // The accepted request used the old PC; its data is stale.
                    if (jump_en_i) drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (drop || jump_en_i) begin
                        drop_next  = 1'b0;
                        pc_load    = jump_en_i;
                        state_next = REQ;
                    end else begin
                        inst_next      = mem_rdata_i;
                        inst_addr_next = pc;
                        valid_next     = 1'b1;
                        state_next     = OUT;
                    end
                end else if (jump_en_i) begin
                    pc_load   = 1'b1;
                    drop_next = 1'b1;
                end
            end
            OUT: begin
                if (jump_en_i) begin
                    pc_load    = 1'b1;
                    valid_next = 1'b0;
                    inst_next  = INST_NOP[IW-1:0];
                    state_next = REQ;
                end else if (!stall_i) begin
                    pc_inc     = 1'b1;
                    valid_next = 1'b0;
                    inst_next  = INST_NOP[IW-1:0];
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req_o    = (state == REQ);
    assign mem_addr_o   = pc;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = valid_q;
    assign hold_flag_o  = ~valid_q;
    assign fsm_state_o  = state;

endmodule
